// File: rtl/embcpumem_nios2_qsys_0_jtag_debug_scan_master.sv
// Virtual-JTAG scan master: one command word becomes UIR/CDR/SDR/UDR/RTI
// on a generated tck, and the captured DR comes back as a response.
module embcpumem_nios2_qsys_0_jtag_debug_scan_master #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int PER  = 2 * TCK_HALF;
  localparam int PW   = (PER > 1) ? $clog2(PER) : 1;
  localparam int CMAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RTL  = (RTI_CYCLES > 0) ? RTI_CYCLES - 1 : 0;

  localparam logic [PW-1:0] PH_RISE  = PW'(TCK_HALF - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(PER - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DR_WIDTH - 1);
  localparam logic [CW-1:0] RTI_LAST = CW'(RTL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI,
    S_RSP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]       ph;
  logic [CW-1:0]       cnt;
  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] rsp_q;
  logic [IR_WIDTH-1:0] ir_cap;
  logic                rdy_en;
  logic                scan;
  logic                rise;
  logic                tick_end;
  logic                accept;

  assign scan     = (state != S_IDLE) && (state != S_RSP);
  assign rise     = scan && (ph == PH_RISE);
  assign tick_end = scan && (ph == PH_LAST);
  assign accept   = cmd_valid && cmd_ready;

  assign cmd_ready  = rdy_en && (state == S_IDLE);
  assign rsp_valid  = (state == S_RSP);
  assign rsp_data   = rsp_q;
  assign rsp_ir_out = ir_cap;

  assign vs_uir = (state == S_UIR);
  assign vs_cdr = (state == S_CDR);
  assign vs_sdr = (state == S_SDR);
  assign vs_udr = (state == S_UDR);

  // The TAP rests in run-test-idle whenever no scan is in flight.
  assign jtag_state_rti = (state == S_IDLE) ||
                          (state == S_RTI)  ||
                          (state == S_RSP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = cmd_skip_ir ? S_CDR : S_UIR;
      S_UIR:  if (tick_end) state_nx = S_CDR;
      S_CDR:  if (tick_end) state_nx = S_SDR;
      S_SDR:  if (tick_end && cnt == BIT_LAST) state_nx = S_UDR;
      S_UDR:  if (tick_end) state_nx = (RTI_CYCLES == 0) ? S_RSP : S_RTI;
      S_RTI:  if (tick_end && cnt == RTI_LAST) state_nx = S_RSP;
      S_RSP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph     <= '0;
      cnt    <= '0;
      sr     <= '0;
      rsp_q  <= '0;
      ir_cap <= '0;
      ir_in  <= '0;
      tck    <= 1'b0;
      tdi    <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      ph     <= (scan && !tick_end) ? ph + PW'(1) : '0;
      if (rise) begin
        tck <= 1'b1;
      end else if (tick_end || !scan) begin
        tck <= 1'b0;
      end
      // tdi moves only at tick boundaries, after the rising-edge shift.
      if (tick_end) begin
        tdi <= (state_nx == S_SDR) ? sr[0] : 1'b0;
        cnt <= (state_nx == state) ? cnt + CW'(1) : '0;
      end
      if (accept) begin
        sr  <= cmd_data;
        cnt <= '0;
        if (!cmd_skip_ir) ir_in <= cmd_ir;
      end
      if (rise && state == S_UIR) ir_cap <= ir_out;
      if (rise && state == S_SDR) sr <= {tdo, sr[DR_WIDTH-1:1]};
      if (tick_end && state == S_SDR && cnt == BIT_LAST) rsp_q <= sr;
    end
  end

endmodule
